// File: rtl/commu_pkg.sv
// Shared types and constants for the SPI transmit frame buffer.
package commu_pkg;

  // Packer FSM states
  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD,
    S_DATA_H,
    S_DATA_L,
    S_SUM,
    S_DROP
  } pack_state_e;

  localparam logic [7:0] HEAD_BYTE_DEF = 8'hA5;
  localparam logic [7:0] IDLE_BYTE_DEF = 8'hFF;

  // Bytes on the wire per frame: header, two bytes per word, checksum
  function automatic int unsigned frm_bytes(input int unsigned frm_words);
    return 2 * frm_words + 2;
  endfunction

endpackage

// File: rtl/commu_byte_fifo.sv
// Byte FIFO with a registered show-ahead head byte; shows IDLE_BYTE while empty.
module commu_byte_fifo
  import commu_pkg::*;
#(
  parameter int unsigned AW        = 8,
  parameter logic [7:0]  IDLE_BYTE = IDLE_BYTE_DEF
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_data_i,
  input  logic          rd_en_i,
  output logic [7:0]    q_o,
  output logic [AW:0]   cnt_o,
  output logic          empty_o
);

  localparam int unsigned Depth = 2 ** AW;

  logic [7:0]  mem_q [Depth];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  q_q, q_d;
  logic        do_wr, do_rd, full;

  // MSB differs with equal index bits only when the pointers are a full lap apart
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cnt_o   = wr_ptr_q - rd_ptr_q;
  assign q_o     = q_q;

  // Pointer advance and next head byte; bypass the write when it becomes the head
  always_comb begin
    do_wr    = wr_en_i & ~full;
    do_rd    = rd_en_i & ~empty_o;
    wr_ptr_d = wr_ptr_q + (AW + 1)'(do_wr);
    rd_ptr_d = rd_ptr_q + (AW + 1)'(do_rd);
    q_d      = IDLE_BYTE;
    if (wr_ptr_d != rd_ptr_d) begin
      if (do_wr && (wr_ptr_q == rd_ptr_d)) begin
        q_d = wr_data_i;
      end else begin
        q_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk_sys) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  // Pointers and registered head byte
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      q_q      <= IDLE_BYTE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      q_q      <= q_d;
    end
  end

endmodule

// File: rtl/commu_tx_frame_buf.sv
// Packs 16-bit words into checksummed byte frames and buffers them for the SPI slave.
module commu_tx_frame_buf
  import commu_pkg::*;
#(
  parameter int unsigned AW        = 8,
  parameter int unsigned FRM_WORDS = 8,
  parameter logic [7:0]  HEAD_BYTE = HEAD_BYTE_DEF,
  parameter logic [7:0]  IDLE_BYTE = IDLE_BYTE_DEF
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          din_vld_i,
  input  logic [15:0]   din_i,
  output logic          din_rdy_o,
  input  logic          req_rd_i,
  output logic [7:0]    req_q_o,
  output logic [AW:0]   fifo_cnt_o,
  output logic [7:0]    drop_cnt_o,
  output logic          underrun_o,
  input  logic          stat_clr_i
);

  localparam int unsigned FrmBytes = frm_bytes(FRM_WORDS);
  // A frame fits when fifo_cnt <= depth - frame size
  localparam logic [AW:0] StartMaxCnt = (AW + 1)'(2 ** AW - FrmBytes);
  localparam logic [6:0]  LastWord    = 7'(FRM_WORDS - 1);

  if (FRM_WORDS < 1 || FRM_WORDS > 64) begin : g_bad_words
    $fatal(1, "FRM_WORDS must be in 1..64");
  end
  if (FrmBytes > 2 ** AW) begin : g_bad_depth
    $fatal(1, "frame does not fit in the FIFO");
  end

  pack_state_e state_q, state_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  lo_q, lo_d;
  logic [6:0]  wcnt_q, wcnt_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic        underrun_q, underrun_d;
  logic        wr_en, drop_inc, fifo_empty;
  logic [7:0]  wr_data;

  // Packer next state, FIFO write and producer handshake
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    lo_d      = lo_q;
    wcnt_d    = wcnt_q;
    wr_en     = 1'b0;
    wr_data   = HEAD_BYTE;
    din_rdy_o = 1'b0;
    drop_inc  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        wcnt_d = '0;
        if (din_vld_i) begin
          state_d = (fifo_cnt_o <= StartMaxCnt) ? S_HEAD : S_DROP;
        end
      end
      S_HEAD: begin
        wr_en   = 1'b1;
        wr_data = HEAD_BYTE;
        sum_d   = '0;
        wcnt_d  = '0;
        state_d = S_DATA_H;
      end
      S_DATA_H: begin
        din_rdy_o = 1'b1;
        if (din_vld_i) begin
          wr_en   = 1'b1;
          wr_data = din_i[15:8];
          lo_d    = din_i[7:0];
          sum_d   = sum_q + din_i[15:8];
          state_d = S_DATA_L;
        end
      end
      S_DATA_L: begin
        wr_en   = 1'b1;
        wr_data = lo_q;
        sum_d   = sum_q + lo_q;
        wcnt_d  = wcnt_q + 7'd1;
        state_d = (wcnt_q == LastWord) ? S_SUM : S_DATA_H;
      end
      S_SUM: begin
        wr_en   = 1'b1;
        wr_data = sum_q;
        state_d = S_IDLE;
      end
      S_DROP: begin
        din_rdy_o = 1'b1;
        if (din_vld_i) begin
          wcnt_d = wcnt_q + 7'd1;
          if (wcnt_q == LastWord) begin
            drop_inc = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Statistics: clear wins over a same-cycle event
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    underrun_d = underrun_q;
    if (stat_clr_i) begin
      drop_cnt_d = '0;
      underrun_d = 1'b0;
    end else begin
      if (drop_inc && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
      if (req_rd_i && fifo_empty)            underrun_d = 1'b1;
    end
  end

  // Packer and statistics registers
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sum_q      <= '0;
      lo_q       <= '0;
      wcnt_q     <= '0;
      drop_cnt_q <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      lo_q       <= lo_d;
      wcnt_q     <= wcnt_d;
      drop_cnt_q <= drop_cnt_d;
      underrun_q <= underrun_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
  assign underrun_o = underrun_q;

  commu_byte_fifo #(
    .AW        (AW),
    .IDLE_BYTE (IDLE_BYTE)
  ) u_fifo (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .rd_en_i   (req_rd_i),
    .q_o       (req_q_o),
    .cnt_o     (fifo_cnt_o),
    .empty_o   (fifo_empty)
  );

endmodule

// File: tb/tb_commu_tx_frame_buf.sv
// Self-checking bench: byte-queue reference model of framed output, random payloads.
module tb_commu_tx_frame_buf;

  localparam int unsigned AW    = 4;
  localparam int unsigned FW    = 2;
  localparam int          DEPTH = 16;
  localparam int          FB    = 2 * FW + 2;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_vld = 1'b0;
  logic [15:0] din = '0;
  logic        din_rdy;
  logic        req_rd = 1'b0;
  logic [7:0]  req_q;
  logic [AW:0] fifo_cnt;
  logic [7:0]  drop_cnt;
  logic        underrun;
  logic        stat_clr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  int model_drops = 0;

  always #5 clk_sys = ~clk_sys;

  commu_tx_frame_buf #(
    .AW        (AW),
    .FRM_WORDS (FW)
  ) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .din_vld_i  (din_vld),
    .din_i      (din),
    .din_rdy_o  (din_rdy),
    .req_rd_i   (req_rd),
    .req_q_o    (req_q),
    .fifo_cnt_o (fifo_cnt),
    .drop_cnt_o (drop_cnt),
    .underrun_o (underrun),
    .stat_clr_i (stat_clr)
  );

  // Reference: a frame on the wire is A5, bytes of each word MSB first, then payload sum mod 256
  function automatic void model_frame(input logic [15:0] w0, input logic [15:0] w1);
    int s;
    s = w0[15:8] + w0[7:0] + w1[15:8] + w1[7:0];
    exp_q.push_back(8'hA5);
    exp_q.push_back(w0[15:8]);
    exp_q.push_back(w0[7:0]);
    exp_q.push_back(w1[15:8]);
    exp_q.push_back(w1[7:0]);
    exp_q.push_back(8'(s % 256));
  endfunction

  // Offer both words of a frame; ok=0 if the DUT stops accepting
  task automatic send_frame(input logic [15:0] w0, input logic [15:0] w1, output bit ok);
    logic [15:0] ws[2];
    int i = 0;
    int guard = 0;
    ws[0] = w0;
    ws[1] = w1;
    ok = 1'b1;
    while (i < FW) begin
      @(negedge clk_sys);
      din_vld = 1'b1;
      din = ws[i];
      if (din_rdy) i++;
      guard++;
      if (guard > 100) begin
        ok = 1'b0;
        break;
      end
    end
    @(negedge clk_sys);
    din_vld = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    n_checks++; if (din_rdy !== 1'b0) begin n_errors++; $display("FAIL reset_din_rdy got %b want 0", din_rdy); end
    n_checks++; if (req_q !== 8'hFF) begin n_errors++; $display("FAIL reset_req_q got %h want ff", req_q); end
    n_checks++; if (fifo_cnt !== '0) begin n_errors++; $display("FAIL reset_fifo_cnt got %0d want 0", fifo_cnt); end
    n_checks++; if (drop_cnt !== 8'h00) begin n_errors++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
    n_checks++; if (underrun !== 1'b0) begin n_errors++; $display("FAIL reset_underrun got %b want 0", underrun); end
    rst_n = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic test_single_frame;
    bit ok;
    model_frame(16'h1234, 16'h5678);
    send_frame(16'h1234, 16'h5678, ok);
    repeat (3) @(negedge clk_sys);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL single_accept got %b want 1", ok); end
    n_checks++; if (fifo_cnt !== 5'(FB)) begin n_errors++; $display("FAIL single_cnt got %0d want %0d", fifo_cnt, FB); end
    n_checks++; if (req_q !== 8'hA5) begin n_errors++; $display("FAIL single_head got %h want a5", req_q); end
    n_checks++; if (exp_q[5] !== 8'h14) begin n_errors++; $display("FAIL single_model_sum got %h want 14", exp_q[5]); end
  endtask

  task automatic test_pop_drain;
    logic [7:0] e;
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      e = exp_q.pop_front();
      n_checks++; if (req_q !== e) begin n_errors++; $display("FAIL drain_byte%0d got %h want %h", i, req_q, e); end
      req_rd = 1'b1;
    end
    @(negedge clk_sys);
    req_rd = 1'b0;
    n_checks++; if (req_q !== 8'hFF) begin n_errors++; $display("FAIL drain_idle got %h want ff", req_q); end
    n_checks++; if (fifo_cnt !== '0) begin n_errors++; $display("FAIL drain_cnt got %0d want 0", fifo_cnt); end
    n_checks++; if (underrun !== 1'b0) begin n_errors++; $display("FAIL drain_underrun got %b want 0", underrun); end
  endtask

  // Fill, overflow by one frame, then admit one that exactly fits
  task automatic test_drop;
    bit ok;
    logic [15:0] w0, w1;
    logic [7:0] e;
    for (int f = 0; f < 3; f++) begin
      w0 = 16'($urandom);
      w1 = 16'($urandom);
      if (DEPTH - exp_q.size() >= FB) model_frame(w0, w1);
      else model_drops++;
      send_frame(w0, w1, ok);
      repeat (3) @(negedge clk_sys);
      n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL drop_accept%0d got %b want 1", f, ok); end
    end
    n_checks++; if (drop_cnt !== 8'(model_drops)) begin n_errors++; $display("FAIL drop_cnt got %0d want %0d", drop_cnt, model_drops); end
    n_checks++; if (fifo_cnt !== 5'(exp_q.size())) begin n_errors++; $display("FAIL drop_fill got %0d want %0d", fifo_cnt, exp_q.size()); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_sys);
      e = exp_q.pop_front();
      n_checks++; if (req_q !== e) begin n_errors++; $display("FAIL drop_pop%0d got %h want %h", i, req_q, e); end
      req_rd = 1'b1;
    end
    @(negedge clk_sys);
    req_rd = 1'b0;
    w0 = 16'($urandom);
    w1 = 16'($urandom);
    if (DEPTH - exp_q.size() >= FB) model_frame(w0, w1);
    else model_drops++;
    send_frame(w0, w1, ok);
    repeat (3) @(negedge clk_sys);
    n_checks++; if (fifo_cnt !== 5'(exp_q.size())) begin n_errors++; $display("FAIL fit_fill got %0d want %0d", fifo_cnt, exp_q.size()); end
    n_checks++; if (drop_cnt !== 8'(model_drops)) begin n_errors++; $display("FAIL fit_drop_cnt got %0d want %0d", drop_cnt, model_drops); end
    test_pop_drain();
  endtask

  // Producer and consumer run concurrently across many pointer wraps
  task automatic test_stream;
    int nf = 20;
    int total = nf * FB;
    int popped = 0;
    int cyc = 0;
    bit prod_done = 1'b0;
    int drops0;
    drops0 = model_drops;
    fork
      begin
        bit ok;
        logic [15:0] w0, w1;
        for (int f = 0; f < nf; f++) begin
          w0 = 16'($urandom);
          w1 = 16'($urandom);
          model_frame(w0, w1);
          send_frame(w0, w1, ok);
          n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL stream_accept%0d got %b want 1", f, ok); end
          repeat ($urandom_range(0, 3)) @(negedge clk_sys);
        end
        prod_done = 1'b1;
      end
      begin
        logic [7:0] e;
        while (!(prod_done && popped == total) && cyc < 5000) begin
          @(negedge clk_sys);
          cyc++;
          n_checks++; if (fifo_cnt > 5'(DEPTH)) begin n_errors++; $display("FAIL stream_cnt got %0d want <= %0d", fifo_cnt, DEPTH); end
          if (fifo_cnt != '0 && $urandom_range(0, 7) != 0) begin
            if (exp_q.size() == 0) begin
              n_checks++; n_errors++;
              $display("FAIL stream_extra got %h want no byte", req_q);
              req_rd = 1'b0;
            end else begin
              e = exp_q.pop_front();
              n_checks++; if (req_q !== e) begin n_errors++; $display("FAIL stream_byte%0d got %h want %h", popped, req_q, e); end
              req_rd = 1'b1;
              popped++;
            end
          end else begin
            req_rd = 1'b0;
          end
        end
        @(negedge clk_sys);
        req_rd = 1'b0;
        n_checks++; if (cyc >= 5000) begin n_errors++; $display("FAIL stream_timeout got %0d bytes want %0d", popped, total); end
      end
    join
    @(negedge clk_sys);
    n_checks++; if (fifo_cnt !== '0) begin n_errors++; $display("FAIL stream_end_cnt got %0d want 0", fifo_cnt); end
    n_checks++; if (underrun !== 1'b0) begin n_errors++; $display("FAIL stream_underrun got %b want 0", underrun); end
    n_checks++; if (drop_cnt !== 8'(drops0)) begin n_errors++; $display("FAIL stream_drops got %0d want %0d", drop_cnt, drops0); end
  endtask

  task automatic test_underrun;
    @(negedge clk_sys);
    req_rd = 1'b1;
    @(negedge clk_sys);
    req_rd = 1'b0;
    n_checks++; if (underrun !== 1'b1) begin n_errors++; $display("FAIL underrun_set got %b want 1", underrun); end
    n_checks++; if (req_q !== 8'hFF) begin n_errors++; $display("FAIL underrun_q got %h want ff", req_q); end
    n_checks++; if (fifo_cnt !== '0) begin n_errors++; $display("FAIL underrun_cnt got %0d want 0", fifo_cnt); end
    req_rd = 1'b1;
    stat_clr = 1'b1;
    @(negedge clk_sys);
    req_rd = 1'b0;
    stat_clr = 1'b0;
    model_drops = 0;
    n_checks++; if (underrun !== 1'b0) begin n_errors++; $display("FAIL underrun_clr got %b want 0", underrun); end
    n_checks++; if (drop_cnt !== 8'h00) begin n_errors++; $display("FAIL drop_clr got %0d want 0", drop_cnt); end
  endtask

  task automatic test_reset_mid_frame;
    int guard = 0;
    bit ok;
    @(negedge clk_sys);
    din_vld = 1'b1;
    din = 16'hBEEF;
    while (!din_rdy && guard < 20) begin
      @(negedge clk_sys);
      guard++;
    end
    n_checks++; if (guard >= 20) begin n_errors++; $display("FAIL mid_rdy_timeout got %0d want < 20", guard); end
    @(posedge clk_sys);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (din_rdy !== 1'b0) begin n_errors++; $display("FAIL mid_din_rdy got %b want 0", din_rdy); end
    n_checks++; if (req_q !== 8'hFF) begin n_errors++; $display("FAIL mid_req_q got %h want ff", req_q); end
    n_checks++; if (fifo_cnt !== '0) begin n_errors++; $display("FAIL mid_cnt got %0d want 0", fifo_cnt); end
    @(negedge clk_sys);
    din_vld = 1'b0;
    @(negedge clk_sys);
    rst_n = 1'b1;
    exp_q.delete();
    model_frame(16'hC3D2, 16'h0FF1);
    send_frame(16'hC3D2, 16'h0FF1, ok);
    repeat (3) @(negedge clk_sys);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL mid_accept got %b want 1", ok); end
    n_checks++; if (fifo_cnt !== 5'(FB)) begin n_errors++; $display("FAIL mid_fill got %0d want %0d", fifo_cnt, FB); end
    test_pop_drain();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_pop_drain();
    test_drop();
    test_stream();
    test_underrun();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
